// File: rtl/lsu_axi_pkg.sv
// Shared types and encodings for the AXI4-Lite load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RESP
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // A dword request on a 32-bit datapath is served as a word.
  function automatic logic [1:0] clamp_size(input logic [1:0] size, input int xlen);
    return (xlen == 32 && size == SZ_D) ? SZ_W : size;
  endfunction

endpackage

// File: rtl/lsu_axi_if.sv
// AXI4-Lite data-side bus between the LSU (master) and the interconnect (slave).
// Every channel uses valid/ready: a beat transfers on a rising edge where both are high;
// valid never drops and the payload never changes before that edge.
interface lsu_axi_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [XLEN-1:0]   rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [XLEN-1:0]   wdata;
  logic [XLEN/8-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready
  );

  modport slave (
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/lsu_axi_align.sv
// Byte-lane steering: store data shift and strobe generation, load extract and extend.
module lsu_align #(
  parameter int XLEN = 32
) (
  input  logic [1:0]                  size_i,
  input  logic [$clog2(XLEN/8)-1:0]   off_i,
  input  logic                        sign_i,
  input  logic [XLEN-1:0]             wdata_i,
  input  logic [XLEN-1:0]             rdata_i,
  output logic [XLEN-1:0]             wdata_o,
  output logic [XLEN/8-1:0]           wstrb_o,
  output logic [XLEN-1:0]             rdata_o
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IDXW = $clog2(XLEN);

  logic [OFFW+2:0] bit_sh;
  logic [NB-1:0]   strb_base;
  logic [XLEN-1:0] raw;
  logic [IDXW-1:0] top_idx;
  logic            fill;
  int              lanes;

  assign bit_sh  = {off_i, 3'b000};
  assign wdata_o = wdata_i << bit_sh;
  assign raw     = rdata_i >> bit_sh;

  always_comb begin
    strb_base = '0;
    lanes     = int'(32'd1 << size_i);
    for (int i = 0; i < NB; i++) begin
      strb_base[i] = (i < lanes);
    end
    wstrb_o = strb_base << off_i;
  end

  // top_idx is the MSB of the accessed quantity; bits above it are filled.
  always_comb begin
    top_idx = IDXW'((32'd8 << size_i) - 32'd1);
    fill    = sign_i & raw[top_idx];
    rdata_o = '0;
    for (int i = 0; i < XLEN; i++) begin
      rdata_o[i] = (i <= int'(top_idx)) ? raw[i] : fill;
    end
  end
endmodule

// File: rtl/lsu_axi.sv
// Load/store unit: one request at a time, AXI4-Lite read or write, registered response.
// Optional macro LSU_MISALIGN_FAULT_EN: misaligned or oversized requests fault without a bus access.
module lsu_axi
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_ren,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_fault,
  output logic [TAG_W-1:0]  rsp_tag,
  lsu_axi_if.master         axi,
  output logic              busy,
  output lsu_state_e        dbg_state
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  lsu_state_e        state_q, state_d;
  logic              arvalid_q, arvalid_d, rready_q, rready_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d, awaddr_q, awaddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]     wstrb_q, wstrb_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_fault_q, rsp_fault_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic [1:0]        size_q, size_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic              signed_q, signed_d;

  logic [1:0]        req_size_eff, al_size;
  logic [OFFW-1:0]   req_off_al, off_mask, al_off;
  logic [ADDR_W-1:0] bus_addr;
  logic [XLEN-1:0]   al_wdata, al_rdata;
  logic [NB-1:0]     al_wstrb;
  logic              misaligned;
  logic              aw_done, w_done;

  // Low offset bits below the access size are dropped so lanes never spill past the bus word.
  assign req_size_eff = clamp_size(req_size, XLEN);
  assign off_mask     = OFFW'((32'd1 << req_size_eff) - 32'd1);
  assign req_off_al   = req_addr[OFFW-1:0] & ~off_mask;
  assign bus_addr     = {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};

`ifdef LSU_MISALIGN_FAULT_EN
  logic [OFFW-1:0] raw_mask;
  assign raw_mask   = OFFW'((32'd1 << req_size) - 32'd1);
  assign misaligned = (req_ren || req_wen) &&
                      (((req_addr[OFFW-1:0] & raw_mask) != '0) || (XLEN == 32 && req_size == SZ_D));
`else
  assign misaligned = 1'b0;
`endif

  assign al_size = (state_q == ST_IDLE) ? req_size_eff : size_q;
  assign al_off  = (state_q == ST_IDLE) ? req_off_al : off_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .size_i  (al_size),
    .off_i   (al_off),
    .sign_i  (signed_q),
    .wdata_i (req_wdata),
    .rdata_i (axi.rdata),
    .wdata_o (al_wdata),
    .wstrb_o (al_wstrb),
    .rdata_o (al_rdata)
  );

  assign aw_done = !awvalid_q || axi.awready;
  assign w_done  = !wvalid_q || axi.wready;

  always_comb begin
    state_d     = state_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    araddr_d    = araddr_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_fault_d = rsp_fault_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_tag_d   = rsp_tag_q;
    size_d      = size_q;
    off_d       = off_q;
    signed_d    = signed_q;
    unique case (state_q)
      ST_IDLE: if (req_valid && req_ready) begin
        rsp_tag_d   = req_tag;
        size_d      = req_size_eff;
        off_d       = req_off_al;
        signed_d    = req_signed;
        rsp_rdata_d = '0;
        rsp_fault_d = 1'b0;
        if (misaligned) begin
          rsp_fault_d = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (req_ren) begin
          araddr_d  = bus_addr;
          arvalid_d = 1'b1;
          state_d   = ST_RD_ADDR;
        end else if (req_wen) begin
          awaddr_d  = bus_addr;
          wdata_d   = al_wdata;
          wstrb_d   = al_wstrb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = ST_WR_REQ;
        end else begin
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RD_ADDR: if (axi.arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = ST_RD_DATA;
      end
      ST_RD_DATA: if (axi.rvalid) begin
        rready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_fault_d = (axi.rresp != AXI_RESP_OKAY);
        rsp_rdata_d = (axi.rresp != AXI_RESP_OKAY) ? '0 : al_rdata;
        state_d     = ST_RESP;
      end
      ST_WR_REQ: begin
        awvalid_d = awvalid_q && !axi.awready;
        wvalid_d  = wvalid_q && !axi.wready;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: if (axi.bvalid) begin
        bready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_fault_d = (axi.bresp != AXI_RESP_OKAY);
        rsp_rdata_d = '0;
        state_d     = ST_RESP;
      end
      ST_RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_tag_q   <= '0;
      size_q      <= SZ_B;
      off_q       <= '0;
      signed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      araddr_q    <= araddr_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_tag_q   <= rsp_tag_d;
      size_q      <= size_d;
      off_q       <= off_d;
      signed_q    <= signed_d;
    end
  end

  assign req_ready   = rst_n && (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state   = state_q;
  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = araddr_q;
  assign axi.rready  = rready_q;
  assign axi.awvalid = awvalid_q;
  assign axi.awaddr  = awaddr_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.bready  = bready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_fault   = rsp_fault_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_tag     = rsp_tag_q;
endmodule

// File: tb/tb_lsu_axi.sv
// Bench for lsu_axi (XLEN=32): directed cases plus randomized traffic against a byte-level memory model.
module tb_lsu_axi;
  import lsu_pkg::*;

  localparam int XLEN = 32;
  localparam int ADDR_W = 32;
  localparam int TAG_W = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              req_valid = 1'b0, req_ready, req_ren = 1'b0, req_wen = 1'b0, req_signed = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [XLEN-1:0]   req_wdata = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic              rsp_valid, rsp_ready = 1'b0, rsp_fault, busy;
  logic [XLEN-1:0]   rsp_rdata;
  logic [TAG_W-1:0]  rsp_tag;
  lsu_state_e        dbg_state;

  lsu_axi_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) axi ();

  lsu_axi #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_ren(req_ren), .req_wen(req_wen),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_tag(req_tag), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault), .rsp_tag(rsp_tag), .axi(axi), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [XLEN-1:0]  exp_q[$];
  logic             exp_fault_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference memory ----------------
  logic [7:0] ref_mem [64];

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input bit sgn);
    int es, nb, base;
    longint unsigned v;
    es   = (size == 2'd3) ? 2 : int'(size);
    nb   = 1 << es;
    base = int'(addr[5:0]) & ~(nb - 1);
    v    = 0;
    for (int i = 0; i < nb; i++) v |= longint'(ref_mem[base + i]) << (8 * i);
    if (sgn && (((v >> (8 * nb - 1)) & 64'd1) != 0)) v |= ~((64'd1 << (8 * nb)) - 64'd1);
    return v[31:0];
  endfunction

  // ---------------- AXI slave ----------------
  logic [31:0] smem [16];
  bit zero_wait = 1'b0, err_mode = 1'b0, r_hold = 1'b0, aw_lag_mode = 1'b0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic [31:0] seen_araddr = '0, seen_awaddr = '0, seen_wdata = '0;
  logic [3:0]  seen_wstrb = '0;

  task automatic set_word(input int idx, input logic [31:0] val);
    smem[idx] = val;
    for (int i = 0; i < 4; i++) ref_mem[4 * idx + i] = val[8 * i +: 8];
  endtask

  initial begin : slave
    bit ar_f, r_f, aw_f, w_f, b_f, aw_got, w_got, r_pend, b_pend;
    int r_dly, b_dly, aw_wait;
    aw_got = 0; w_got = 0; r_pend = 0; b_pend = 0; r_dly = 0; b_dly = 0; aw_wait = -1;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = 2'b00;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 2'b00;
    forever begin
      @(negedge clk);
      ar_f = rst_n && axi.arvalid && axi.arready;
      r_f  = rst_n && axi.rvalid && axi.rready;
      aw_f = rst_n && axi.awvalid && axi.awready;
      w_f  = rst_n && axi.wvalid && axi.wready;
      b_f  = rst_n && axi.bvalid && axi.bready;
      if (ar_f) begin seen_araddr = axi.araddr; ar_cnt++; end
      if (r_f) r_cnt++;
      if (aw_f) begin seen_awaddr = axi.awaddr; aw_cnt++; aw_got = 1; aw_wait = -1; end
      if (w_f) begin
        seen_wdata = axi.wdata; seen_wstrb = axi.wstrb; w_cnt++; w_got = 1;
        if (aw_lag_mode && !aw_got) aw_wait = 3;
      end
      if (b_f) b_cnt++;
      @(posedge clk); #1;
      if (!rst_n) begin
        aw_got = 0; w_got = 0; r_pend = 0; b_pend = 0; aw_wait = -1;
        axi.rvalid = 0; axi.bvalid = 0;
      end else begin
        if (r_f) axi.rvalid = 0;
        if (ar_f) begin r_pend = 1; r_dly = zero_wait ? 0 : $urandom_range(0, 2); end
        if (r_pend && !axi.rvalid && !r_hold) begin
          if (r_dly == 0) begin
            axi.rvalid = 1; axi.rdata = smem[seen_araddr[5:2]];
            axi.rresp = err_mode ? 2'b10 : 2'b00; r_pend = 0;
          end else r_dly--;
        end
        if (b_f) axi.bvalid = 0;
        if (aw_got && w_got) begin
          if (!err_mode)
            for (int i = 0; i < 4; i++)
              if (seen_wstrb[i]) smem[seen_awaddr[5:2]][8 * i +: 8] = seen_wdata[8 * i +: 8];
          aw_got = 0; w_got = 0; b_pend = 1; b_dly = zero_wait ? 0 : $urandom_range(0, 2);
        end
        if (b_pend && !axi.bvalid) begin
          if (b_dly == 0) begin
            axi.bvalid = 1; axi.bresp = err_mode ? 2'b10 : 2'b00; b_pend = 0;
          end else b_dly--;
        end
      end
      axi.arready = zero_wait ? 1'b1 : 1'($urandom_range(0, 1));
      axi.wready  = zero_wait ? 1'b1 : 1'($urandom_range(0, 1));
      if (aw_lag_mode) begin
        if (aw_wait > 0) aw_wait--;
        axi.awready = (aw_wait == 0);
      end else begin
        axi.awready = zero_wait ? 1'b1 : 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- handshake stability monitor ----------------
  logic p_rst = 0, p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_rsv = 0, p_rsr = 0;
  logic [31:0] p_araddr = '0, p_awaddr = '0, p_wdata = '0, p_rdata = '0;
  always @(negedge clk) begin
    if (p_rst && rst_n) begin
      if (p_arv && !p_arr) begin
        chk("arvalid_hold", axi.arvalid, 1); chk("araddr_stable", axi.araddr, p_araddr);
      end
      if (p_awv && !p_awr) begin
        chk("awvalid_hold", axi.awvalid, 1); chk("awaddr_stable", axi.awaddr, p_awaddr);
      end
      if (p_wv && !p_wr) begin
        chk("wvalid_hold", axi.wvalid, 1); chk("wdata_stable", axi.wdata, p_wdata);
      end
      if (p_rsv && !p_rsr) begin
        chk("rsp_valid_hold", rsp_valid, 1); chk("rsp_rdata_stable", rsp_rdata, p_rdata);
      end
    end
    p_rst = rst_n; p_arv = axi.arvalid; p_arr = axi.arready; p_awv = axi.awvalid; p_awr = axi.awready;
    p_wv = axi.wvalid; p_wr = axi.wready; p_rsv = rsp_valid; p_rsr = rsp_ready;
    p_araddr = axi.araddr; p_awaddr = axi.awaddr; p_wdata = axi.wdata; p_rdata = rsp_rdata;
  end

  // ---------------- driver ----------------
  task automatic run_txn(input bit ren, input bit wen, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit err,
                         input int hold, input bit early, input int exp_lat);
    logic [63:0] tag;
    logic [31:0] exp_rd, e_wd, e_rd;
    logic [3:0]  e_st;
    logic        exp_f, e_f;
    logic [63:0] e_tag;
    bit mis, do_rd, do_wr;
    int es, nb, base, off, a0, r0, aw0, w0, b0, n, lat;
    tag  = {$urandom, $urandom};
    es   = (size == 2'd3) ? 2 : int'(size);
    nb   = 1 << es;
    base = int'(addr[5:0]) & ~(nb - 1);
    off  = base & 3;
    mis  = 0;
`ifdef LSU_MISALIGN_FAULT_EN
    mis = (ren || wen) && (((int'(addr[5:0]) % (1 << int'(size))) != 0) || size == 2'd3);
`endif
    do_rd  = ren && !mis;
    do_wr  = !ren && wen && !mis;
    exp_f  = mis || ((do_rd || do_wr) && err);
    exp_rd = (do_rd && !err) ? ref_load(addr, size, sgn) : 32'd0;
    e_wd   = wdata << (8 * off);
    e_st   = 4'(((1 << nb) - 1) << off);
    if (do_wr && !err) for (int i = 0; i < nb; i++) ref_mem[base + i] = wdata[8 * i +: 8];
    exp_q.push_back(exp_rd); exp_fault_q.push_back(exp_f); exp_tag_q.push_back(tag);
    err_mode = err;
    a0 = ar_cnt; r0 = r_cnt; aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    @(posedge clk); #1;
    req_valid = 1; req_ren = ren; req_wen = wen; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; req_tag = tag; rsp_ready = early;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    e_rd = exp_q.pop_front(); e_f = exp_fault_q.pop_front(); e_tag = exp_tag_q.pop_front();
    if (!req_ready) begin
      chk("accept_timeout", 0, 1); req_valid = 0; rsp_ready = 0; return;
    end
    @(posedge clk); #1;
    req_valid = 0; req_wdata = $urandom; req_tag = '0;
    lat = 1;
    while (!rsp_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) begin
      chk("rsp_timeout", 0, 1); rsp_ready = 0; return;
    end
    if (exp_lat > 0) chk("latency", 64'(lat), 64'(exp_lat));
    chk("req_ready_in_resp", req_ready, 0);
    chk("busy_in_resp", busy, 1);
    chk("rsp_rdata", rsp_rdata, e_rd);
    chk("rsp_fault", rsp_fault, e_f);
    chk("rsp_tag", rsp_tag, e_tag);
    if (!early) begin
      repeat (hold) begin
        @(posedge clk); #1;
        chk("rsp_hold_valid", rsp_valid, 1);
        chk("rsp_hold_rdata", rsp_rdata, e_rd);
        chk("rsp_hold_tag", rsp_tag, e_tag);
      end
      rsp_ready = 1;
    end
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("req_ready_after", req_ready, 1);
    chk("ar_count", 64'(ar_cnt - a0), 64'(do_rd));
    chk("r_count", 64'(r_cnt - r0), 64'(do_rd));
    chk("aw_count", 64'(aw_cnt - aw0), 64'(do_wr));
    chk("w_count", 64'(w_cnt - w0), 64'(do_wr));
    chk("b_count", 64'(b_cnt - b0), 64'(do_wr));
    if (do_rd) chk("araddr", seen_araddr, {addr[31:2], 2'b00});
    if (do_wr) begin
      chk("awaddr", seen_awaddr, {addr[31:2], 2'b00});
      chk("wdata", seen_wdata, e_wd);
      chk("wstrb", seen_wstrb, e_st);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    for (int i = 0; i < 16; i++) set_word(i, $urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, rsp_valid, rsp_fault}, 0);
    chk("rst_araddr", axi.araddr, 0);
    chk("rst_awaddr", axi.awaddr, 0);
    chk("rst_wdata", axi.wdata, 0);
    chk("rst_wstrb", axi.wstrb, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("req_ready_out_of_rst", req_ready, 1);

    zero_wait = 1;
    set_word(0, 32'h80AA_BBCC);
    run_txn(1, 0, SZ_B, 1, 32'h8000_0003, 0, 0, 0, 0, 3);
    chk("lb_direct_ref", ref_load(32'h8000_0003, SZ_B, 1), 32'hFFFF_FF80);
    run_txn(0, 1, SZ_W, 0, 32'h8000_0010, 32'hCAFE_F00D, 0, 0, 0, 3);
    run_txn(0, 0, SZ_W, 0, 32'h8000_0020, 0, 0, 0, 0, 1);
    run_txn(1, 0, SZ_W, 0, 32'h8000_0010, 0, 0, 0, 1, 3);
    aw_lag_mode = 1;
    run_txn(0, 1, SZ_H, 0, 32'h0000_0102, 32'h0000_1234, 0, 0, 0, 0);
    aw_lag_mode = 0;
    run_txn(1, 0, SZ_H, 0, 32'h0000_0102, 0, 0, 0, 0, 3);
    run_txn(1, 0, SZ_W, 1, 32'h8000_0008, 0, 1, 0, 0, 3);
    run_txn(0, 1, SZ_B, 0, 32'h8000_0009, 32'h55, 1, 0, 0, 3);
    run_txn(1, 0, SZ_W, 0, 32'h0000_0002, 0, 0, 0, 0, 0);
    run_txn(1, 0, SZ_D, 1, 32'h8000_0014, 0, 0, 0, 0, 0);
    run_txn(1, 1, SZ_H, 1, 32'h8000_0006, 32'hFFFF, 0, 5, 0, 3);

    // reset while the read data beat is outstanding
    r_hold = 1;
    @(posedge clk); #1;
    req_valid = 1; req_ren = 1; req_wen = 0; req_size = SZ_W; req_addr = 32'h8000_0004;
    @(posedge clk); #1;
    req_valid = 0;
    n = 0;
    while (!axi.rready && n < 20) begin @(posedge clk); #1; n++; end
    chk("rd_data_reached", axi.rready, 1);
    rst_n = 0;
    @(posedge clk); #1;
    chk("midrst_valids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, rsp_valid}, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ready", req_ready, 0);
    @(posedge clk); #1;
    r_hold = 0;
    rst_n = 1;
    #1;
    chk("midrst_release_ready", req_ready, 1);

    zero_wait = 0;
    for (int t = 0; t < 150; t++) begin
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 32'h8000_0000 | 32'($urandom_range(0, 63)), $urandom,
              ($urandom_range(0, 7) == 0), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_axi.md
# lsu_axi

Parametrised load/store unit sitting between the execute stage and the data-side AXI4-Lite interconnect; successor to the single-width LSU. Accepts one memory request at a time via a valid/ready handshake, runs the AXI read (AR/R) or write (AW/W/B) sequence, and returns aligned, size-masked, sign-extended load data with a fault flag and an opaque sideband tag. Adds byte-lane steering for sub-word accesses, independent AW/W handshakes, bus-error reporting and a response backpressure handshake.

## Interface
- XLEN, 32, data width; legal values 32 or 64. NB = XLEN/8 byte lanes.
- ADDR_W, 32, address width.
- TAG_W, 64, width of the sideband tag (pc, rd, writeback controls) carried from request to response unchanged.
- Clocking: one clock; reset is synchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE and rst_n=1.
- req_ren / req_wen  in  1 each  load / store; both low = no-op passthrough.
- req_size  in  2  0=byte, 1=half, 2=word, 3=dword (XLEN=64 only).
- req_signed  in  1  sign-extend load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, LSB-aligned.
- req_tag  in  TAG_W  sideband.
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  consumer accepts.
- rsp_rdata  out  XLEN  extended load data; 0 for stores, no-ops and faults.
- rsp_fault  out  1  access fault.
- rsp_tag  out  TAG_W  captured req_tag.
- araddr/arvalid/arready, rdata[XLEN]/rresp[2]/rvalid/rready: AXI read channels.
- awaddr/awvalid/awready, wdata[XLEN]/wstrb[NB]/wvalid/wready, bresp[2]/bvalid/bready: AXI write channels.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE: on req_valid&&req_ready capture all req_* fields. ren -> RD_ADDR; else wen -> WR_REQ; else RESP (rdata 0, fault 0). ren has priority if both set.
- Offset off = addr[log2(NB)-1:0]. Bus address = req_addr with offset bits cleared.
- Store: wdata = req_wdata << 8*off; wstrb = ((1<<(1<<size))-1) << off, truncated to NB bits.
- Load: raw = rdata >> 8*off; keep low 8<<size bits; req_signed replicates top kept bit, else zero-fill; size=max width passes raw.
- RD_ADDR: arvalid=1 until arready -> RD_DATA. RD_DATA: rready=1; on rvalid capture -> RESP.
- WR_REQ: awvalid and wvalid rise together; each drops on its own handshake; when both complete (same or different cycles) -> WR_RESP. WR_RESP: bready=1; on bvalid -> RESP.
- Nonzero rresp/bresp: rsp_fault=1, rsp_rdata=0; never retried.
- RESP: rsp_valid=1; on rsp_ready -> IDLE.

## Timing
- Reset: state IDLE; arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_fault, busy = 0; araddr, awaddr, wdata, wstrb, rsp_rdata, rsp_tag = 0; req_ready=0 while rst_n=0.
- All AXI and rsp_* outputs registered; req_ready and busy decoded from state.
- Load, zero wait states: accept at cycle 0, arvalid 1, rready 2, rsp_valid 3.
- Store, zero wait states: accept 0, aw/wvalid 1, bready 2, rsp_valid 3. No-op: rsp_valid at cycle 1.
- Valid signals never drop before their handshake; payloads stable while valid.
- rsp_ready may be high before rsp_valid: RESP lasts one cycle; req_ready returns the following cycle (no same-cycle re-accept).
- rst_n low mid-transaction: next edge forces reset values; outstanding AXI beat abandoned (interconnect shares the reset).

## Configuration
- LSU_MISALIGN_FAULT_EN defined: request with addr not a multiple of 1<<size, or size=3 at XLEN=32, skips the bus and goes straight to RESP with rsp_fault=1, rsp_rdata=0.
- Undefined: offset bits below size are ignored (address aligned down), size=3 at XLEN=32 treated as word, and the bus access is always performed.

## Structure
- Package lsu_pkg: state enum, size encodings (SZ_B, SZ_H, SZ_W, SZ_D), AXI_RESP_OKAY=2'b00.
- Sub-module lsu_align: combinational store lane shift/strobe generation and load extract/extend, parametrised by XLEN.

## Test plan
- XLEN=32, lb signed addr 0x8000_0003, rdata 0x80AA_BBCC -> araddr 0x8000_0000, rsp_rdata 0xFFFF_FF80, fault 0.
- XLEN=32, sh addr 0x102, wdata 0x0000_1234 -> awaddr 0x100, wdata 0x1234_0000, wstrb 4'b1100; awready 3 cycles after wready -> single bresp, rsp_valid once.
- XLEN=64, lwu addr 0x4, rdata 0xDEAD_BEEF_0000_0001 -> rsp_rdata 0x0000_0000_DEAD_BEEF.
- Load with rresp=2'b10 -> rsp_fault 1, rsp_rdata 0, tag returned, FSM back to IDLE.
- LSU_MISALIGN_FAULT_EN: lw addr 0x2 -> no arvalid, rsp_valid at cycle 1 with fault 1; without macro: araddr 0x0, word returned.
- rsp_ready held low 5 cycles -> rsp_valid/rdata/tag stable; rst_n low during RD_DATA -> all valids 0 next edge, req_ready 1 after release.
